ppi_bus_sequencer: RTL and testbench
====================================

Name: ppi_bus_sequencer

Overview:
- Synchronous front-end that turns single-cycle CPU-side requests into correctly timed PPI bus cycles: a0/a1, rdb/wrb, data drive and PPI reset.
- Sits directly upstream of the PPI. Provides address setup, strobe pulse width and hold time in clock cycles, and captures read data before rdb rises.
- One transaction in flight; one response pulse per transaction.

Parameters:
- SETUP_CYC, 2, cycles address/data held stable before strobe falls (min 1)
- PULSE_CYC, 3, cycles strobe held low (min 1)
- HOLD_CYC, 2, cycles address/data held after strobe rises (min 1)
- RESET_CYC, 4, cycles ppi_reset stays high after reset deasserts (min 1)
- CNT_W, 4, width of the shared phase counter; must hold max(all *_CYC)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  2  PPI register address {a1,a0}
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse, transaction finished
- rsp_rdata  out  8  read data, valid with rsp_valid on reads
- rsp_err  out  1  CWR verify mismatch (0 when CWR_VERIFY_EN is undefined)
- ppi_a0, ppi_a1  out  1 each  PPI address
- ppi_rdb  out  1  PPI read strobe, active low
- ppi_wrb  out  1  PPI write strobe, active low
- ppi_reset  out  1  PPI reset
- ppi_data_o  out  8  data driven toward PPI
- ppi_data_oe  out  1  enable for the external tristate on the data bus
- ppi_data_i  in  8  data bus as seen from the PPI side

Behaviour:
- All outputs are registered.
- Reset values: ppi_rdb=1, ppi_wrb=1, ppi_data_oe=0, ppi_data_o=0, ppi_a1/a0=0, ppi_reset=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State is RST.
- FSM states: RST, IDLE, SETUP, STROBE, HOLD, RESP. Extra states are added under the optional feature.
- RST: ppi_reset=1 for RESET_CYC cycles after reset falls, then ppi_reset=0 and go to IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata. Next cycle: drive ppi_a1/a0, and if write also drive ppi_data_o=wdata with ppi_data_oe=1. Go to SETUP.
- SETUP: lasts SETUP_CYC cycles, strobes high.
- STROBE: lasts PULSE_CYC cycles with ppi_wrb=0 (write) or ppi_rdb=0 (read).
  - On reads, rsp_rdata is loaded from ppi_data_i on the clock edge that ends the last STROBE cycle.
- HOLD: lasts HOLD_CYC cycles, strobes high, address and data still driven.
- RESP: rsp_valid=1 for exactly one cycle; ppi_data_oe=0; go to IDLE. There is no response backpressure.
- Latency: acceptance edge to rsp_valid = 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (8 at defaults).
- Back-to-back: req_ready is 0 from the acceptance edge until RESP is reached, and returns to 1 in the cycle after RESP.
- ppi_rdb and ppi_wrb are never low simultaneously. Address never changes while either strobe is low.
- ppi_data_oe is never 1 during a read transaction.
- Reset mid-transaction: outputs take reset values immediately (asynchronously), the transaction is dropped with no rsp_valid, and the RST sequence restarts.
- rsp_rdata keeps its last value between reads.

Optional Feature:
- Macro CWR_VERIFY_EN.
- Defined:
  - After a write to address 3 finishes HOLD, the FSM does not enter RESP. It runs an automatic read of address 3 through VSETUP, VSTROBE and VHOLD, using the same cycle counts.
  - The captured value is compared with the written byte. rsp_err=1 on mismatch, registered with rsp_valid.
  - rsp_rdata = captured value.
  - Latency for CWR writes becomes 1+2*(SETUP_CYC+PULSE_CYC+HOLD_CYC).
- Undefined: rsp_err is tied to 0 and CWR writes follow the plain write timing.

Test Plan:
- Reset release → ppi_reset high exactly RESET_CYC=4 cycles after reset falls, req_ready rises in the next cycle, strobes stay 1.
- Write addr=3, data=0x9B → ppi_a1/a0=11 and ppi_data_o=0x9B with oe=1 for 2 cycles, then wrb low 3 cycles, then 2 hold cycles. rsp_valid arrives 8 cycles after acceptance; with CWR_VERIFY_EN and the model returning 0x9B, rsp_err=0.
- Read addr=0 with the model driving ppi_data_i=0xA5 during STROBE → rdb low 3 cycles, oe=0 throughout, rsp_rdata=0xA5, rsp_valid pulses once.
- req_valid held high for 3 requests (write 0x11 to addr 2, read addr 1, write 0x67 to addr 1) → exactly 3 rsp_valid pulses, req_ready low during each transaction, strobes never overlap.
- Assert reset during STROBE of a write → wrb returns to 1 and oe to 0 in the same cycle, no rsp_valid, ppi_reset sequence restarts.
- CWR_VERIFY_EN: write 0x80 to addr 3 with the model returning 0x9E on readback → rsp_err=1, rsp_rdata=0x9E, latency 15 cycles.

Source files
------------

// File: rtl/ppi_bus_sequencer_if.sv
// CPU-side request/response and PPI pin bundle for ppi_bus_sequencer.
// slave = the sequencer, master = the CPU side plus the PPI model.
interface ppi_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       ppi_a0;
  logic       ppi_a1;
  logic       ppi_rdb;
  logic       ppi_wrb;
  logic       ppi_reset;
  logic [7:0] ppi_data_o;
  logic       ppi_data_oe;
  logic [7:0] ppi_data_i;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ppi_data_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ppi_a0, ppi_a1, ppi_rdb, ppi_wrb, ppi_reset, ppi_data_o, ppi_data_oe
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ppi_data_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ppi_a0, ppi_a1, ppi_rdb, ppi_wrb, ppi_reset, ppi_data_o, ppi_data_oe
  );
endinterface

// File: rtl/ppi_bus_sequencer.sv
// Turns single-cycle CPU requests into timed PPI bus cycles (setup/strobe/hold).
// Define CWR_VERIFY_EN to add an automatic read-back check after writes to address 3.
module ppi_bus_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int RESET_CYC = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  ppi_bus_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_RST,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
`ifdef CWR_VERIFY_EN
    ,
    S_VSETUP,
    S_VSTROBE,
    S_VHOLD
`endif
  } state_t;

  // SETUP counts one extra step: its first cycle is the address-launch cycle.
  localparam logic [CNT_W-1:0] SETUP_END  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_END  = CNT_W'(RESET_CYC);
`ifdef CWR_VERIFY_EN
  localparam logic [CNT_W-1:0] VSETUP_LAST = CNT_W'(SETUP_CYC - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       a_q, a_d;
  logic             rdb_q, rdb_d;
  logic             wrb_q, wrb_d;
  logic             ppi_reset_q, ppi_reset_d;
  logic [7:0]       data_o_q, data_o_d;
  logic             oe_q, oe_d;
  logic             we_q, we_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
`ifdef CWR_VERIFY_EN
  logic             rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    a_d         = a_q;
    rdb_d       = rdb_q;
    wrb_d       = wrb_q;
    ppi_reset_d = ppi_reset_q;
    data_o_d    = data_o_q;
    oe_d        = oe_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef CWR_VERIFY_EN
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      S_RST: begin
        if (cnt_q == RESET_END) begin
          state_d     = S_IDLE;
          ppi_reset_d = 1'b0;
          cnt_d       = '0;
        end
      end

      // req_ready is only raised one cycle after entering IDLE from RST
      S_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && bus.req_valid) begin
          ready_d = 1'b0;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          a_d      = addr_q;
          oe_d     = we_q;
          data_o_d = we_q ? wdata_q : data_o_q;
        end
        if (cnt_q == SETUP_END) begin
          state_d = S_STROBE;
          cnt_d   = '0;
          wrb_d   = !we_q;
          rdb_d   = we_q;
        end
      end

      // Read data is sampled on the same edge that raises rdb.
      S_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          wrb_d   = 1'b1;
          rdb_d   = 1'b1;
          if (!we_q) rsp_rdata_d = bus.ppi_data_i;
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          oe_d  = 1'b0;
`ifdef CWR_VERIFY_EN
          if (we_q && addr_q == 2'd3) begin
            state_d = S_VSETUP;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
`else
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
`endif
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
      end

`ifdef CWR_VERIFY_EN
      // Read-back of the control word just written; address 3 is still driven.
      S_VSETUP: begin
        if (cnt_q == VSETUP_LAST) begin
          state_d = S_VSTROBE;
          cnt_d   = '0;
          rdb_d   = 1'b0;
        end
      end

      S_VSTROBE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d     = S_VHOLD;
          cnt_d       = '0;
          rdb_d       = 1'b1;
          rsp_rdata_d = bus.ppi_data_i;
        end
      end

      S_VHOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (rsp_rdata_q != wdata_q);
        end
      end
`endif

      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      rdb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      ppi_reset_q <= 1'b1;
      data_o_q    <= '0;
      oe_q        <= 1'b0;
`ifdef CWR_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      a_q         <= a_d;
      rdb_q       <= rdb_d;
      wrb_q       <= wrb_d;
      ppi_reset_q <= ppi_reset_d;
      data_o_q    <= data_o_d;
      oe_q        <= oe_d;
`ifdef CWR_VERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Request holding registers need no reset: they are written before any use.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.ppi_a0      = a_q[0];
  assign bus.ppi_a1      = a_q[1];
  assign bus.ppi_rdb     = rdb_q;
  assign bus.ppi_wrb     = wrb_q;
  assign bus.ppi_reset   = ppi_reset_q;
  assign bus.ppi_data_o  = data_o_q;
  assign bus.ppi_data_oe = oe_q;
`ifdef CWR_VERIFY_EN
  assign bus.rsp_err     = rsp_err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: vector table of single transactions
// plus hand-written back-to-back and reset-abort sequences.
module tb_ppi_bus_sequencer;

`ifdef CWR_VERIFY_EN
  localparam bit CWR = 1'b1;
`else
  localparam bit CWR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppi_bus_sequencer_if bif();

  ppi_bus_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // PPI model: returns model_val while rdb is low
  logic [7:0] model_val = 8'h00;
  assign bif.ppi_data_i = bif.ppi_rdb ? 8'h00 : model_val;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Continuous protocol monitor, sampled on the falling edge
  int   overlap_cnt = 0;
  int   oe_rd_cnt   = 0;
  int   addr_chg_cnt = 0;
  logic [1:0] prev_a = 2'b00;
  logic       prev_strb = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (!bif.ppi_rdb && !bif.ppi_wrb) overlap_cnt <= overlap_cnt + 1;
      if (!bif.ppi_rdb && bif.ppi_data_oe) oe_rd_cnt <= oe_rd_cnt + 1;
      if (prev_strb && !(bif.ppi_rdb && bif.ppi_wrb) && ({bif.ppi_a1, bif.ppi_a0} != prev_a))
        addr_chg_cnt <= addr_chg_cnt + 1;
    end
    prev_a    <= {bif.ppi_a1, bif.ppi_a0};
    prev_strb <= !(bif.ppi_rdb && bif.ppi_wrb);
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_rdb"},    bif.ppi_rdb, 1);
    chk({tag, "_wrb"},    bif.ppi_wrb, 1);
    chk({tag, "_oe"},     bif.ppi_data_oe, 0);
    chk({tag, "_data_o"}, bif.ppi_data_o, 0);
    chk({tag, "_addr"},   {bif.ppi_a1, bif.ppi_a0}, 0);
    chk({tag, "_ppirst"}, bif.ppi_reset, 1);
    chk({tag, "_ready"},  bif.req_ready, 0);
    chk({tag, "_rspv"},   bif.rsp_valid, 0);
    chk({tag, "_rdata"},  bif.rsp_rdata, 0);
    chk({tag, "_err"},    bif.rsp_err, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ppi_reset_hi_%0d", i), bif.ppi_reset, 1);
      chk($sformatf("ready_lo_%0d", i), bif.req_ready, 0);
      chk($sformatf("strobes_idle_%0d", i), {bif.ppi_rdb, bif.ppi_wrb}, 2'b11);
      chk($sformatf("no_rsp_rst_%0d", i), bif.rsp_valid, 0);
    end
    @(posedge clk); #1;
    chk("ppi_reset_fall", bif.ppi_reset, 0);
    chk("ready_lo_at_fall", bif.req_ready, 0);
    @(posedge clk); #1;
    chk("ready_rise", bif.req_ready, 1);
  endtask

  task automatic run_txn(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         input logic [7:0] rv, output int lat, output int wlow,
                         output int rlow, output int oe_cnt, output int rdy_hi,
                         output logic [7:0] d_strb, output logic [1:0] a_strb,
                         output logic [7:0] rdata, output logic err);
    int   w;
    logic got;
    lat = -1; wlow = 0; rlow = 0; oe_cnt = 0; rdy_hi = 0;
    d_strb = 8'h00; a_strb = 2'b00; rdata = 8'h00; err = 1'b0; got = 1'b0;
    model_val = rv;
    @(negedge clk);
    w = 0;
    while (!bif.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!bif.ppi_wrb) wlow++;
      if (!bif.ppi_rdb) rlow++;
      if (bif.ppi_data_oe) oe_cnt++;
      if (bif.req_ready) rdy_hi++;
      if (!got && (!bif.ppi_wrb || !bif.ppi_rdb)) begin
        got    = 1'b1;
        d_strb = bif.ppi_data_o;
        a_strb = {bif.ppi_a1, bif.ppi_a0};
      end
      if (bif.rsp_valid) begin
        lat   = n;
        rdata = bif.rsp_rdata;
        err   = bif.rsp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] rv;
    int         lat;
    logic [7:0] rdata;
    logic       err;
    int         wlow;
    int         rlow;
  } vec_t;

  vec_t vt [7];

  initial begin
    int   lat, wlow, rlow, oe_cnt, rdy_hi, w;
    logic [7:0] d_strb, rdata;
    logic [1:0] a_strb;
    logic err;
    int   acc, rsp, cyc, first_acc, last_rsp, ready_hi;
    logic accept_now;
    logic [7:0] b2b_rd;
    logic seen;

    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = 2'b00;
    bif.req_wdata = 8'h00;

    //            we addr wd     rv     lat              rdata                     err  wl rl
    vt[0] = '{1'b1, 2'd3, 8'h9B, 8'h9B, CWR ? 15 : 8, CWR ? 8'h9B : 8'h00, 1'b0, 3, CWR ? 3 : 0};
    vt[1] = '{1'b0, 2'd0, 8'h00, 8'hA5, 8,            8'hA5,               1'b0, 0, 3};
    vt[2] = '{1'b1, 2'd2, 8'h11, 8'h00, 8,            8'hA5,               1'b0, 3, 0};
    vt[3] = '{1'b0, 2'd1, 8'h00, 8'h3C, 8,            8'h3C,               1'b0, 0, 3};
    vt[4] = '{1'b1, 2'd3, 8'h80, 8'h9E, CWR ? 15 : 8, CWR ? 8'h9E : 8'h3C, CWR,  3, CWR ? 3 : 0};
    vt[5] = '{1'b0, 2'd3, 8'h00, 8'hFF, 8,            8'hFF,               1'b0, 0, 3};
    vt[6] = '{1'b1, 2'd1, 8'h67, 8'h00, 8,            8'hFF,               1'b0, 3, 0};

    #12;
    check_reset_values("por");
    release_reset();

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].we, vt[i].addr, vt[i].wd, vt[i].rv, lat, wlow, rlow, oe_cnt, rdy_hi,
              d_strb, a_strb, rdata, err);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].rdata);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
      chk($sformatf("v%0d_wrb_low", i), wlow, vt[i].wlow);
      chk($sformatf("v%0d_rdb_low", i), rlow, vt[i].rlow);
      chk($sformatf("v%0d_oe_cycles", i), oe_cnt, vt[i].we ? 7 : 0);
      chk($sformatf("v%0d_ready_busy", i), rdy_hi, 0);
      chk($sformatf("v%0d_addr", i), a_strb, vt[i].addr);
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), d_strb, vt[i].wd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_one_cycle", i), bif.rsp_valid, 0);
      chk($sformatf("v%0d_ready_back", i), bif.req_ready, 1);
    end

    // Back-to-back: req_valid held high across three requests
    model_val = 8'h5A;
    acc = 0; rsp = 0; cyc = 0; first_acc = -1; last_rsp = -1; ready_hi = 0; b2b_rd = 8'h00;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = 2'd2; bif.req_wdata = 8'h11;
    while (rsp < 3 && cyc < 100) begin
      accept_now = bif.req_ready && bif.req_valid;
      @(posedge clk); #1;
      cyc++;
      if (bif.req_ready) ready_hi++;
      if (accept_now) begin
        if (acc == 0) first_acc = cyc;
        acc++;
        if (acc == 1) begin
          bif.req_we = 1'b0; bif.req_addr = 2'd1; bif.req_wdata = 8'h00;
        end else if (acc == 2) begin
          bif.req_we = 1'b1; bif.req_addr = 2'd1; bif.req_wdata = 8'h67;
        end else begin
          bif.req_valid = 1'b0;
        end
      end
      if (bif.rsp_valid) begin
        rsp++;
        last_rsp = cyc;
        if (rsp == 2) b2b_rd = bif.rsp_rdata;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_responses", rsp, 3);
    chk("b2b_span", last_rsp - first_acc, 28);
    chk("b2b_ready_hi_samples", ready_hi, 2);
    chk("b2b_read_data", b2b_rd, 8'h5A);

    // Reset asserted while a write strobe is low
    model_val = 8'h00;
    @(negedge clk);
    w = 0;
    while (!bif.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = 2'd2; bif.req_wdata = 8'h3C;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (!bif.ppi_wrb) seen = 1'b1;
    end
    chk("abort_wrb_seen_low", seen, 1);
    chk("abort_oe_before", bif.ppi_data_oe, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("abort");
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp_in_reset", bif.rsp_valid, 0);
    release_reset();

    // Recovery: plain read after the aborted write
    run_txn(1'b0, 2'd2, 8'h00, 8'hC3, lat, wlow, rlow, oe_cnt, rdy_hi, d_strb, a_strb, rdata, err);
    chk("recover_latency", lat, 8);
    chk("recover_rdata", rdata, 8'hC3);
    chk("recover_rdb_low", rlow, 3);

    @(negedge clk);
    chk("mon_strobe_overlap", overlap_cnt, 0);
    chk("mon_oe_during_read", oe_rd_cnt, 0);
    chk("mon_addr_change_in_strobe", addr_chg_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
